// File: rtl/fifo_serializer_pkg.sv
// Shared types and constants for the fifo_serializer slice.
// The PARITY state only exists when FIFO_SERIALIZER_PARITY_EN is defined.
package fifo_serializer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
`ifdef FIFO_SERIALIZER_PARITY_EN
    PARITY,
`endif
    STOP
  } ser_state_t;

  localparam logic TX_IDLE_LVL  = 1'b1;
  localparam logic TX_START_LVL = 1'b0;

  // Counter width for a range of n values, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_serializer_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
module bit_timer
  import fifo_serializer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int TW = cnt_width(CLKS_PER_BIT);

  logic [TW-1:0] cnt;

  assign tick = (cnt == TW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TW'(1);
    end
  end

endmodule

// File: rtl/fifo_serializer.sv
// Drains the fifo one word at a time and sends it LSB-first as an async serial frame.
// Define FIFO_SERIALIZER_PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_serializer
  import fifo_serializer_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fifo_out,
  input  logic             fifo_empty,
  output logic             fifo_read_en,
  input  logic             tx_enable,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int BW = cnt_width(WIDTH);

  ser_state_t       state;
  ser_state_t       state_next;
  logic             tick;
  logic             timer_clear;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift;
  logic             last_bit;
`ifdef FIFO_SERIALIZER_PARITY_EN
  logic             parity_bit;
`endif

  // Every state change restarts both the bit timer and the bit counter
  assign timer_clear = (state_next != state);
  assign last_bit    = (bit_cnt == BW'(WIDTH - 1));

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(timer_clear),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (tx_enable && !fifo_empty) state_next = POP;
      POP:   state_next = LOAD;
      LOAD:  state_next = START;
      START: if (tick) state_next = DATA;
`ifdef FIFO_SERIALIZER_PARITY_EN
      DATA:   if (tick && last_bit) state_next = PARITY;
      PARITY: if (tick) state_next = STOP;
`else
      DATA:  if (tick && last_bit) state_next = STOP;
`endif
      STOP:  if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The pop strobe is registered so it is high exactly for the POP cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      fifo_read_en <= 1'b0;
      bit_cnt      <= '0;
      shift        <= '0;
`ifdef FIFO_SERIALIZER_PARITY_EN
      parity_bit   <= 1'b0;
`endif
    end else begin
      fifo_read_en <= (state_next == POP);
      if (state_next != state) begin
        bit_cnt <= '0;
      end else if (state == DATA && tick) begin
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (state == LOAD) begin
        shift <= fifo_out;
      end else if (state == DATA && tick) begin
        shift <= shift >> 1;
      end
`ifdef FIFO_SERIALIZER_PARITY_EN
      if (state == LOAD) begin
        parity_bit <= ^fifo_out;
      end
`endif
    end
  end

  assign busy = (state != IDLE);

  always_comb begin
    tx   = TX_IDLE_LVL;
    done = 1'b0;
    case (state)
      START:  tx = TX_START_LVL;
      DATA:   tx = shift[0];
`ifdef FIFO_SERIALIZER_PARITY_EN
      PARITY: tx = parity_bit;
`endif
      STOP:   done = tick;
      default: tx = TX_IDLE_LVL;
    endcase
  end

endmodule
